// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared types for the AXI4-Lite command master
package axi4lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [2:0] {
      IDLE,
      WR_AW,
      WR_B,
      RD_AR,
      RD_R,
      RESP
   } mst_state_t;

   localparam int TIMER_WIDTH = 16;

   function automatic logic is_wait_state(input mst_state_t s);
      return (s == WR_AW) || (s == WR_B) || (s == RD_AR) || (s == RD_R);
   endfunction

endpackage

// File: rtl/axi4lite_master_if.sv
// rtl/axi4lite_master_if.sv - command/response and AXI4-Lite signals of the master
interface axi4lite_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_write;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   logic [ADDR_WIDTH-1:0] m_axi_awaddr;
   logic                  m_axi_awvalid;
   logic                  m_axi_awready;
   logic [DATA_WIDTH-1:0] m_axi_wdata;
   logic                  m_axi_wvalid;
   logic                  m_axi_wready;
   logic [1:0]            m_axi_bresp;
   logic                  m_axi_bvalid;
   logic                  m_axi_bready;
   logic [ADDR_WIDTH-1:0] m_axi_araddr;
   logic                  m_axi_arvalid;
   logic                  m_axi_arready;
   logic [DATA_WIDTH-1:0] m_axi_rdata;
   logic                  m_axi_rvalid;
   logic                  m_axi_rready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
      output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wvalid, m_axi_bready,
      output m_axi_araddr, m_axi_arvalid, m_axi_rready,
      input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
      input  m_axi_arready, m_axi_rdata, m_axi_rvalid
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
      input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wvalid, m_axi_bready,
      input  m_axi_araddr, m_axi_arvalid, m_axi_rready,
      output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
      output m_axi_arready, m_axi_rdata, m_axi_rvalid
   );
endinterface

// File: rtl/axi4lite_mst_timer.sv
// rtl/axi4lite_mst_timer.sv - bus-wait counter; expires when the count reaches LIMIT
module axi4lite_mst_timer
   import axi4lite_pkg::*;
#(
   parameter int LIMIT = 255
)(
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_count,
   output logic o_expire
);
   localparam logic [TIMER_WIDTH-1:0] LIMIT_W = TIMER_WIDTH'(LIMIT);

   logic [TIMER_WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= '0;
      end else if (i_count && (r_count != LIMIT_W)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expire = i_count && (r_count == LIMIT_W);
endmodule

// File: rtl/axi4lite_master.sv
// rtl/axi4lite_master.sv - one-outstanding AXI4-Lite master driven by a cmd/rsp handshake
// Optional bus-wait timeout: AXI4L_MST_TIMEOUT_EN
module axi4lite_master
   import axi4lite_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 6,
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic              m_axi_aclk,
   input  logic              m_axi_aresetn,
   axi4lite_master_if.master bus
);
   mst_state_t            r_state,     w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr,      w_addr_nxt;
   logic [DATA_WIDTH-1:0] r_wdata,     w_wdata_nxt;
   logic [DATA_WIDTH-1:0] r_rdata,     w_rdata_nxt;
   logic                  r_write,     w_write_nxt;
   logic                  r_err,       w_err_nxt;
   logic                  r_aw_done,   w_aw_done_nxt;
   logic                  r_w_done,    w_w_done_nxt;
   logic                  w_accept, w_aw_hs, w_w_hs, w_expire;

   assign bus.cmd_ready     = (r_state == IDLE) && m_axi_aresetn;
   assign bus.rsp_valid     = (r_state == RESP);
   assign bus.rsp_write     = r_write;
   assign bus.rsp_rdata     = r_rdata;
   assign bus.rsp_err       = r_err;
   assign bus.m_axi_awaddr  = r_addr;
   assign bus.m_axi_araddr  = r_addr;
   assign bus.m_axi_wdata   = r_wdata;
   assign bus.m_axi_awvalid = (r_state == WR_AW) && !r_aw_done;
   assign bus.m_axi_wvalid  = (r_state == WR_AW) && !r_w_done;
   assign bus.m_axi_bready  = (r_state == WR_B);
   assign bus.m_axi_arvalid = (r_state == RD_AR);
   assign bus.m_axi_rready  = (r_state == RD_R);

   assign w_accept = bus.cmd_valid && bus.cmd_ready;
   assign w_aw_hs  = bus.m_axi_awvalid && bus.m_axi_awready;
   assign w_w_hs   = bus.m_axi_wvalid && bus.m_axi_wready;

`ifdef AXI4L_MST_TIMEOUT_EN
   axi4lite_mst_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
      .clk      (m_axi_aclk),
      .rst_n    (m_axi_aresetn),
      .i_load   (w_accept),
      .i_count  (is_wait_state(r_state)),
      .o_expire (w_expire)
   );
`else
   // No timer in this build; the limit only appears to keep the parameter referenced.
   assign w_expire = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_write   <= 1'b0;
         r_err     <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_addr    <= w_addr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_rdata   <= w_rdata_nxt;
         r_write   <= w_write_nxt;
         r_err     <= w_err_nxt;
         r_aw_done <= w_aw_done_nxt;
         r_w_done  <= w_w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_addr_nxt    = r_addr;
      w_wdata_nxt   = r_wdata;
      w_rdata_nxt   = r_rdata;
      w_write_nxt   = r_write;
      w_err_nxt     = r_err;
      w_aw_done_nxt = r_aw_done;
      w_w_done_nxt  = r_w_done;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_addr_nxt    = bus.cmd_addr;
               w_wdata_nxt   = bus.cmd_wdata;
               w_write_nxt   = bus.cmd_write;
               w_rdata_nxt   = '0;
               w_err_nxt     = 1'b0;
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
               w_state_nxt   = bus.cmd_write ? WR_AW : RD_AR;
            end
         end
         WR_AW: begin
            // AW and W may complete in either order; leave once both are done.
            w_aw_done_nxt = r_aw_done || w_aw_hs;
            w_w_done_nxt  = r_w_done || w_w_hs;
            if (w_aw_done_nxt && w_w_done_nxt) begin
               w_state_nxt = WR_B;
            end else if (w_expire) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = RESP;
            end
         end
         WR_B: begin
            if (bus.m_axi_bvalid) begin
               w_err_nxt   = (resp_t'(bus.m_axi_bresp) != OKAY);
               w_state_nxt = RESP;
            end else if (w_expire) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RD_AR: begin
            if (bus.m_axi_arready) begin
               w_state_nxt = RD_R;
            end else if (w_expire) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RD_R: begin
            if (bus.m_axi_rvalid) begin
               w_rdata_nxt = bus.m_axi_rdata;
               w_err_nxt   = 1'b0;
               w_state_nxt = RESP;
            end else if (w_expire) begin
               w_rdata_nxt = '0;
               w_err_nxt   = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_axi4lite_master.sv
// tb/tb_axi4lite_master.sv - directed self-checking bench with a delay-programmable slave BFM
// Timeout scenario runs only when AXI4L_MST_TIMEOUT_EN is defined
module tb_axi4lite_master;
   localparam int TIMEOUT = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   axi4lite_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus ();

   axi4lite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .m_axi_aclk    (clk),
      .m_axi_aresetn (rst_n),
      .bus           (bus)
   );

   // Slave BFM
   int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
   logic [1:0]  bresp_cfg = 2'b00;
   int          aw_wait, w_wait, ar_wait, r_wait;
   int          write_count = 0;
   logic        aw_got, w_got, b_pend, r_pend;
   logic [5:0]  aw_addr, ar_addr;
   logic [31:0] w_data;
   logic [1:0]  b_resp_r;
   logic [31:0] mem [16];

   assign bus.m_axi_awready = bus.m_axi_awvalid && (aw_wait == aw_delay);
   assign bus.m_axi_wready  = bus.m_axi_wvalid && (w_wait == w_delay);
   assign bus.m_axi_arready = bus.m_axi_arvalid && (ar_wait == ar_delay);
   assign bus.m_axi_bvalid  = b_pend;
   assign bus.m_axi_bresp   = b_resp_r;
   assign bus.m_axi_rvalid  = r_pend && (r_wait == r_delay);
   assign bus.m_axi_rdata   = r_pend ? mem[ar_addr[5:2]] : 32'h0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_wait <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
         aw_addr <= '0; ar_addr <= '0; w_data <= '0; b_resp_r <= 2'b00;
         for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 + 32'(i);
      end else begin
         if (bus.m_axi_awvalid) begin
            if (bus.m_axi_awready) begin
               aw_got <= 1'b1; aw_addr <= bus.m_axi_awaddr; aw_wait <= 0;
            end else aw_wait <= aw_wait + 1;
         end else aw_wait <= 0;
         if (bus.m_axi_wvalid) begin
            if (bus.m_axi_wready) begin
               w_got <= 1'b1; w_data <= bus.m_axi_wdata; w_wait <= 0;
            end else w_wait <= w_wait + 1;
         end else w_wait <= 0;
         if (aw_got && w_got && !b_pend) begin
            mem[aw_addr[5:2]] <= w_data;
            b_pend <= 1'b1; b_resp_r <= bresp_cfg;
            aw_got <= 1'b0; w_got <= 1'b0;
            write_count <= write_count + 1;
         end
         if (b_pend && bus.m_axi_bready) b_pend <= 1'b0;
         if (bus.m_axi_arvalid) begin
            if (bus.m_axi_arready) begin
               r_pend <= 1'b1; ar_addr <= bus.m_axi_araddr; ar_wait <= 0; r_wait <= 0;
            end else ar_wait <= ar_wait + 1;
         end else ar_wait <= 0;
         if (r_pend) begin
            if (bus.m_axi_rvalid && bus.m_axi_rready) r_pend <= 1'b0;
            else if (!bus.m_axi_rvalid) r_wait <= r_wait + 1;
         end
      end
   end

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic send_cmd(input logic wr, input logic [5:0] a, input logic [31:0] d, output bit ok);
      ok = 1'b0;
      bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_wdata = d;
      for (int i = 0; i < 50; i++) begin
         if (bus.cmd_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus.rsp_valid) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic take_rsp();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
         failures++; $display("FAIL reset_cmd_ready got=%b exp=0", bus.cmd_ready);
      end
      checks++;
      if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_bready,
           bus.m_axi_rready, bus.rsp_valid, bus.rsp_err, bus.rsp_write} !== 8'h00) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=00000000",
            {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_bready,
             bus.m_axi_rready, bus.rsp_valid, bus.rsp_err, bus.rsp_write});
      end
      checks++;
      if ({bus.m_axi_awaddr, bus.m_axi_wdata, bus.rsp_rdata} !== 70'h0) begin
         failures++; $display("FAIL reset_data awaddr=%h wdata=%h rdata=%h exp=0",
            bus.m_axi_awaddr, bus.m_axi_wdata, bus.rsp_rdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         failures++; $display("FAIL idle_cmd_ready got=%b exp=1", bus.cmd_ready);
      end
   endtask

   task automatic test_write();
      bit ok;
      int wc0 = write_count;
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 6'h08; bus.cmd_wdata = 32'hDEADBEEF;
      checks++;
      if ({bus.m_axi_awvalid, bus.m_axi_wvalid} !== 2'b00) begin
         failures++; $display("FAIL wr_valid_before_accept got=%b exp=00", {bus.m_axi_awvalid, bus.m_axi_wvalid});
      end
      send_cmd(1'b1, 6'h08, 32'hDEADBEEF, ok);
      checks++;
      if (!ok || {bus.m_axi_awvalid, bus.m_axi_wvalid} !== 2'b11) begin
         failures++; $display("FAIL wr_valid_rise accepted=%0d got=%b exp=11", ok, {bus.m_axi_awvalid, bus.m_axi_wvalid});
      end
      checks++;
      if (bus.m_axi_awaddr !== 6'h08 || bus.m_axi_wdata !== 32'hDEADBEEF) begin
         failures++; $display("FAIL wr_addr_data got=%h/%h exp=08/deadbeef", bus.m_axi_awaddr, bus.m_axi_wdata);
      end
      wait_rsp(ok);
      checks++;
      if (!ok || {bus.rsp_write, bus.rsp_err} !== 2'b10 || bus.rsp_rdata !== 32'h0) begin
         failures++; $display("FAIL wr_rsp seen=%0d write=%b err=%b rdata=%h exp=1/0/0",
            ok, bus.rsp_write, bus.rsp_err, bus.rsp_rdata);
      end
      checks++;
      if (mem[2] !== 32'hDEADBEEF || write_count - wc0 != 1) begin
         failures++; $display("FAIL wr_mem got=%h writes=%0d exp=deadbeef/1", mem[2], write_count - wc0);
      end
      take_rsp();
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         failures++; $display("FAIL wr_back_to_idle cmd_ready=%b rsp_valid=%b exp=1/0", bus.cmd_ready, bus.rsp_valid);
      end
   endtask

   task automatic test_read_delayed();
      bit ok;
      int stall = 0;
      r_delay = 3;
      send_cmd(1'b0, 6'h08, 32'h0, ok);
      for (int i = 0; i < 100; i++) begin
         if (bus.rsp_valid) break;
         if (bus.m_axi_rready && !bus.m_axi_rvalid) stall++;
         @(negedge clk);
      end
      checks++;
      if (stall != 3) begin
         failures++; $display("FAIL rd_rready_stall got=%0d exp=3", stall);
      end
      wait_rsp(ok);
      checks++;
      if (!ok || bus.rsp_rdata !== 32'hDEADBEEF || {bus.rsp_write, bus.rsp_err} !== 2'b00) begin
         failures++; $display("FAIL rd_rsp seen=%0d rdata=%h write=%b err=%b exp=deadbeef/0/0",
            ok, bus.rsp_rdata, bus.rsp_write, bus.rsp_err);
      end
      take_rsp();
      r_delay = 0;
   endtask

   task automatic test_split_handshake();
      bit ok;
      int wc0 = write_count;
      aw_delay = 2;
      send_cmd(1'b1, 6'h10, 32'h0BADF00D, ok);
      @(negedge clk);
      checks++;
      if ({bus.m_axi_awvalid, bus.m_axi_wvalid} !== 2'b10) begin
         failures++; $display("FAIL split_w_drop got=%b exp=10", {bus.m_axi_awvalid, bus.m_axi_wvalid});
      end
      wait_rsp(ok);
      checks++;
      if (!ok || bus.rsp_err !== 1'b0 || write_count - wc0 != 1 || mem[4] !== 32'h0BADF00D) begin
         failures++; $display("FAIL split_result seen=%0d err=%b writes=%0d mem=%h exp=1/0/1/0badf00d",
            ok, bus.rsp_err, write_count - wc0, mem[4]);
      end
      take_rsp();
      checks++;
      if (bus.rsp_valid !== 1'b0 || write_count - wc0 != 1) begin
         failures++; $display("FAIL split_single_rsp rsp_valid=%b writes=%0d exp=0/1", bus.rsp_valid, write_count - wc0);
      end
      aw_delay = 0;
   endtask

   task automatic test_bresp_err();
      bit ok;
      int bad = 0;
      bresp_cfg = 2'b10;
      send_cmd(1'b1, 6'h3C, 32'h12345678, ok);
      wait_rsp(ok);
      for (int i = 0; i < 4; i++) begin
         if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_write !== 1'b1 ||
             bus.rsp_rdata !== 32'h0 || bus.cmd_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (!ok || bad != 0) begin
         failures++; $display("FAIL bresp_hold seen=%0d unstable_cycles=%0d exp=1/0", ok, bad);
      end
      checks++;
      if (mem[15] !== 32'h12345678) begin
         failures++; $display("FAIL bresp_mem got=%h exp=12345678", mem[15]);
      end
      take_rsp();
      bresp_cfg = 2'b00;
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen = 1'b0;
      r_delay = 20;
      send_cmd(1'b0, 6'h08, 32'h0, ok);
      for (int i = 0; i < 20; i++) begin
         if (bus.m_axi_rready) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!seen) begin
         failures++; $display("FAIL mid_reach_rd_r got=0 exp=1");
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.cmd_ready, bus.m_axi_rready, bus.m_axi_arvalid, bus.m_axi_awvalid,
           bus.m_axi_wvalid, bus.m_axi_bready, bus.rsp_valid, bus.rsp_err, bus.rsp_write} !== 9'h0 ||
          bus.m_axi_araddr !== 6'h0 || bus.rsp_rdata !== 32'h0) begin
         failures++; $display("FAIL mid_reset_outputs ctrl=%b araddr=%h rdata=%h exp=0",
            {bus.cmd_ready, bus.m_axi_rready, bus.m_axi_arvalid, bus.m_axi_awvalid,
             bus.m_axi_wvalid, bus.m_axi_bready, bus.rsp_valid, bus.rsp_err, bus.rsp_write},
            bus.m_axi_araddr, bus.rsp_rdata);
      end
      r_delay = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_cmd(1'b0, 6'h04, 32'h0, ok);
      wait_rsp(ok);
      checks++;
      if (!ok || bus.rsp_rdata !== 32'hA5A50001 || bus.rsp_err !== 1'b0) begin
         failures++; $display("FAIL mid_post_read seen=%0d rdata=%h err=%b exp=a5a50001/0", ok, bus.rsp_rdata, bus.rsp_err);
      end
      take_rsp();
   endtask

`ifdef AXI4L_MST_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      int ar_cycles = 0;
      ar_delay = 1000;
      send_cmd(1'b0, 6'h0C, 32'h0, ok);
      for (int i = 0; i < 100; i++) begin
         if (bus.rsp_valid) break;
         if (bus.m_axi_arvalid) ar_cycles++;
         @(negedge clk);
      end
      checks++;
      if (ar_cycles != TIMEOUT + 1 || bus.m_axi_arvalid !== 1'b0) begin
         failures++; $display("FAIL timeout_arvalid cycles=%0d arvalid=%b exp=%0d/0", ar_cycles, bus.m_axi_arvalid, TIMEOUT + 1);
      end
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
         failures++; $display("FAIL timeout_rsp valid=%b err=%b rdata=%h exp=1/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
      end
      take_rsp();
      ar_delay = 0;
   endtask
`endif

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      test_write();
      test_read_delayed();
      test_split_handshake();
      test_bresp_err();
      test_reset_mid();
`ifdef AXI4L_MST_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
